rojobot_wb_hub: RTL and testbench

ROJOBOT_WB_HUB -- requirements
Module: rojobot_wb_hub

---
 rtl/rojobot_wb_hub_pkg.sv | 17 +
 rtl/rojobot_wb_chan.sv | 56 +++++
 rtl/rojobot_wb_hub.sv | 131 +++++++++++++
 tb/tb_rojobot_wb_hub.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rojobot_wb_hub_pkg.sv
// Shared constants for the Rojobot Wishbone hub: register offsets, STATUS bits,
// channel limits and the default hub identifier.
package rojobot_wb_hub_pkg;
    localparam int         MAX_BOTS       = 8;
    localparam logic [7:0] HUB_ID_DEFAULT = 8'hB0;

    localparam logic [4:0] OFF_INFO   = 5'h00;
    localparam logic [4:0] OFF_CTRL   = 5'h04;
    localparam logic [4:0] OFF_STATUS = 5'h08;
    localparam logic [4:0] OFF_IRQEN  = 5'h0C;

    localparam logic [4:0] OFF_IRQSUM = 5'h00;
    localparam logic [4:0] OFF_ID     = 5'h04;

    localparam int ST_PEND = 0;
    localparam int ST_OVR  = 1;
endpackage

// File: rtl/rojobot_wb_chan.sv
// One Rojobot channel: control byte, info snapshot, pending/overrun flags,
// interrupt enable and rising-edge detection of the update level.
module rojobot_wb_chan
    import rojobot_wb_hub_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_info,
    input  logic        i_upd,
    input  logic        i_wr_ctrl,
    input  logic        i_wr_status,
    input  logic        i_wr_irqen,
    input  logic [7:0]  i_wdat,
    output logic [31:0] o_info,
    output logic [7:0]  o_ctrl,
    output logic        o_pend,
    output logic        o_ovr,
    output logic        o_irqen
);
    logic        r_upd_d;
    logic [31:0] r_info;
    logic [7:0]  r_ctrl;
    logic        r_pend, r_ovr, r_irqen;
    logic        w_evt, w_clr_pend, w_clr_ovr;

    assign w_evt      = i_upd & ~r_upd_d;
    assign w_clr_pend = i_wr_status & i_wdat[ST_PEND];
    assign w_clr_ovr  = i_wr_status & i_wdat[ST_OVR];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_upd_d <= 1'b0;
            r_info  <= '0;
            r_ctrl  <= '0;
            r_pend  <= 1'b0;
            r_ovr   <= 1'b0;
            r_irqen <= 1'b0;
        end else begin
            r_upd_d <= i_upd;
            if (i_wr_ctrl)  r_ctrl  <= i_wdat;
            if (i_wr_irqen) r_irqen <= i_wdat[0];
            if (w_evt)      r_info  <= i_info;
            // Set beats clear; an event racing a PEND clear is not an overrun.
            if (w_evt)           r_pend <= 1'b1;
            else if (w_clr_pend) r_pend <= 1'b0;
            if (w_evt && r_pend && !w_clr_pend) r_ovr <= 1'b1;
            else if (w_clr_ovr)                 r_ovr <= 1'b0;
        end
    end

    assign o_info  = r_info;
    assign o_ctrl  = r_ctrl;
    assign o_pend  = r_pend;
    assign o_ovr   = r_ovr;
    assign o_irqen = r_irqen;
endmodule

// File: rtl/rojobot_wb_hub.sv
// Wishbone classic slave serving NUM_BOTS Rojobot channels: address decode,
// single-cycle ack/err, registered read mux and aggregate interrupt.
module rojobot_wb_hub
    import rojobot_wb_hub_pkg::*;
#(
    parameter int         NUM_BOTS = 2,
    parameter logic [7:0] HUB_ID   = HUB_ID_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [31:0]             wb_adr_i,
    input  logic [31:0]             wb_dat_i,
    input  logic [3:0]              wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic [2:0]              wb_cti_i,
    input  logic [1:0]              wb_bte_i,
    output logic [31:0]             wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    wb_rtry_o,
    input  logic [32*NUM_BOTS-1:0]  bot_info_i,
    input  logic [NUM_BOTS-1:0]     bot_upd_i,
    output logic [8*NUM_BOTS-1:0]   bot_ctrl_o,
    output logic                    irq_o
);
    logic                         r_ack, r_err, r_irq;
    logic [31:0]                  r_dat;
    logic [NUM_BOTS-1:0][31:0]    w_info;
    logic [NUM_BOTS-1:0][7:0]     w_ctrl;
    logic [NUM_BOTS-1:0]          w_pend, w_ovr, w_irqen;
    logic [MAX_BOTS-1:0]          w_irq_vec;
    logic [4:0]                   w_off;
    logic [2:0]                   w_idx;
    logic                         w_glb, w_idx_ok, w_req, w_err, w_wr_go;
    logic [31:0]                  w_rdat, w_sel_info;
    logic [7:0]                   w_sel_ctrl;
    logic                         w_sel_pend, w_sel_ovr, w_sel_irqen;
    logic                         w_unused;

    assign w_unused = ^{wb_adr_i[31:9], wb_dat_i[31:8], wb_sel_i[3:1], wb_cti_i, wb_bte_i};

    assign w_off    = wb_adr_i[4:0];
    assign w_idx    = wb_adr_i[7:5];
    assign w_glb    = wb_adr_i[8];
    assign w_idx_ok = {29'b0, w_idx} < NUM_BOTS;
    assign w_req    = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
    assign w_wr_go  = w_req & wb_we_i & ~w_err & wb_sel_i[0];

    always_comb begin
        w_irq_vec   = '0;
        w_sel_info  = '0;
        w_sel_ctrl  = '0;
        w_sel_pend  = 1'b0;
        w_sel_ovr   = 1'b0;
        w_sel_irqen = 1'b0;
        for (int n = 0; n < NUM_BOTS; n++) begin
            w_irq_vec[n] = w_pend[n] & w_irqen[n];
            if (w_idx == 3'(n)) begin
                w_sel_info  = w_info[n];
                w_sel_ctrl  = w_ctrl[n];
                w_sel_pend  = w_pend[n];
                w_sel_ovr   = w_ovr[n];
                w_sel_irqen = w_irqen[n];
            end
        end
    end

    // Anything not matched below (bad index, hole in the map) errors out.
    always_comb begin
        w_err  = 1'b1;
        w_rdat = '0;
        if (w_glb) begin
            case (w_off)
                OFF_IRQSUM: begin w_err = wb_we_i; w_rdat = {24'h0, w_irq_vec}; end
                OFF_ID:     begin w_err = wb_we_i; w_rdat = {16'h0, 8'(NUM_BOTS), HUB_ID}; end
                default:    ;
            endcase
        end else if (w_idx_ok) begin
            case (w_off)
                OFF_INFO:   begin w_err = wb_we_i; w_rdat = w_sel_info; end
                OFF_CTRL:   begin w_err = 1'b0; w_rdat = {24'h0, w_sel_ctrl}; end
                OFF_STATUS: begin w_err = 1'b0; w_rdat = {30'h0, w_sel_ovr, w_sel_pend}; end
                OFF_IRQEN:  begin w_err = 1'b0; w_rdat = {31'h0, w_sel_irqen}; end
                default:    ;
            endcase
        end
    end

    for (genvar n = 0; n < NUM_BOTS; n++) begin : g_chan
        logic w_hit;
        assign w_hit = w_wr_go & ~w_glb & (w_idx == 3'(n));
        rojobot_wb_chan u_chan (
            .clk         (clk),
            .rstn        (rstn),
            .i_info      (bot_info_i[n*32 +: 32]),
            .i_upd       (bot_upd_i[n]),
            .i_wr_ctrl   (w_hit & (w_off == OFF_CTRL)),
            .i_wr_status (w_hit & (w_off == OFF_STATUS)),
            .i_wr_irqen  (w_hit & (w_off == OFF_IRQEN)),
            .i_wdat      (wb_dat_i[7:0]),
            .o_info      (w_info[n]),
            .o_ctrl      (w_ctrl[n]),
            .o_pend      (w_pend[n]),
            .o_ovr       (w_ovr[n]),
            .o_irqen     (w_irqen[n])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
            r_irq <= 1'b0;
        end else begin
            r_ack <= w_req & ~w_err;
            r_err <= w_req & w_err;
            r_dat <= (w_req && !w_err) ? w_rdat : '0;
            r_irq <= |w_irq_vec;
        end
    end

    assign wb_ack_o   = r_ack;
    assign wb_err_o   = r_err;
    assign wb_dat_o   = r_dat;
    assign wb_rtry_o  = 1'b0;
    assign irq_o      = r_irq;
    assign bot_ctrl_o = w_ctrl;
endmodule

// File: tb/tb_rojobot_wb_hub.sv
// Directed self-checking bench for rojobot_wb_hub with NUM_BOTS=2.
module tb_rojobot_wb_hub;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i = 0, wb_cyc_i = 0, wb_stb_i = 0;
    logic [2:0]  wb_cti_i = '0;
    logic [1:0]  wb_bte_i = '0;
    logic        wb_ack_o, wb_err_o, wb_rtry_o, irq_o;
    logic [63:0] bot_info_i = '0;
    logic [1:0]  bot_upd_i = '0;
    logic [15:0] bot_ctrl_o;
    int checks = 0, errors = 0;
    logic        ack, err;
    logic [31:0] rd;

    rojobot_wb_hub #(.NUM_BOTS(2), .HUB_ID(8'hB0)) dut (
        .clk(clk), .rstn(rstn), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i),
        .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .wb_rtry_o(wb_rtry_o), .bot_info_i(bot_info_i), .bot_upd_i(bot_upd_i),
        .bot_ctrl_o(bot_ctrl_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic o_ack, output logic o_err,
                       output logic [31:0] o_rd);
        @(negedge clk);
        wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        wb_cyc_i = 1; wb_stb_i = 1;
        @(posedge clk); #1;
        o_ack = wb_ack_o; o_err = wb_err_o; o_rd = wb_dat_o;
        @(negedge clk);
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    endtask

    task automatic pulse(input int n);
        @(negedge clk); bot_upd_i[n] = 1'b1;
        @(negedge clk); bot_upd_i[n] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk); #1;
        checks++; if ({wb_ack_o, wb_err_o, irq_o, wb_rtry_o} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {wb_ack_o, wb_err_o, irq_o, wb_rtry_o}); end
        checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h want 0", wb_dat_o); end
        checks++; if (bot_ctrl_o !== 16'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", bot_ctrl_o); end
        @(negedge clk); rstn = 1'b1;
    endtask

    task automatic test_ctrl();
        bus(1, 32'h024, 32'h0000_00A5, 4'h1, ack, err, rd);
        checks++; if ({ack, err} !== 2'b10) begin errors++; $display("FAIL ctrl_wr_ack got %b want 10", {ack, err}); end
        checks++; if (bot_ctrl_o !== 16'hA500) begin errors++; $display("FAIL ctrl_out got %h want a500", bot_ctrl_o); end
        bus(0, 32'h024, 32'h0, 4'h0, ack, err, rd);
        checks++; if (ack !== 1'b1 || rd !== 32'h0000_00A5) begin errors++; $display("FAIL ctrl_rd got ack %b %h want 1 000000a5", ack, rd); end
        bus(1, 32'h004, 32'h77, 4'h0, ack, err, rd);
        checks++; if (ack !== 1'b1 || bot_ctrl_o !== 16'hA500) begin errors++; $display("FAIL ctrl_sel0 got ack %b %h want 1 a500", ack, bot_ctrl_o); end
    endtask

    task automatic test_update();
        bot_info_i = {32'h0, 32'h1122_3344};
        pulse(0);
        bus(0, 32'h000, 32'h0, 4'h0, ack, err, rd);
        checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL upd_info got %h want 11223344", rd); end
        bus(0, 32'h008, 32'h0, 4'h0, ack, err, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL upd_pend got %h want 1", rd); end
        pulse(0);
        bus(0, 32'h008, 32'h0, 4'h0, ack, err, rd);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL upd_ovr got %h want 3", rd); end
        bus(1, 32'h008, 32'h3, 4'h1, ack, err, rd);
        bus(0, 32'h008, 32'h0, 4'h0, ack, err, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL upd_w1c got %h want 0", rd); end
        bus(0, 32'h020, 32'h0, 4'h0, ack, err, rd);
        checks++; if (rd !== 32'h0 || irq_o !== 1'b0) begin errors++; $display("FAIL upd_indep got %h irq %b want 0 0", rd, irq_o); end
    endtask

    task automatic test_irq();
        bus(1, 32'h02C, 32'h1, 4'h1, ack, err, rd);
        bot_info_i[63:32] = 32'hCAFE_0001;
        pulse(1);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_latency got %b want 0", irq_o); end
        @(posedge clk); #1;
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_rise got %b want 1", irq_o); end
        bus(0, 32'h100, 32'h0, 4'h0, ack, err, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL irq_sum got %h want 2", rd); end
        // PEND clear racing a new update
        @(negedge clk);
        bot_upd_i[1] = 1; wb_we_i = 1; wb_adr_i = 32'h028; wb_dat_i = 32'h1; wb_sel_i = 4'h1;
        wb_cyc_i = 1; wb_stb_i = 1;
        @(posedge clk); #1;
        checks++; if (wb_ack_o !== 1'b1 || irq_o !== 1'b1) begin errors++; $display("FAIL race_pend_ack got %b irq %b want 1 1", wb_ack_o, irq_o); end
        @(negedge clk); bot_upd_i[1] = 0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        bus(0, 32'h028, 32'h0, 4'h0, ack, err, rd);
        checks++; if (rd !== 32'h1 || irq_o !== 1'b1) begin errors++; $display("FAIL race_pend got %h irq %b want 1 1", rd, irq_o); end
        pulse(1);
        // OVR clear racing an overrun
        @(negedge clk);
        bot_upd_i[1] = 1; wb_we_i = 1; wb_adr_i = 32'h028; wb_dat_i = 32'h2; wb_sel_i = 4'h1;
        wb_cyc_i = 1; wb_stb_i = 1;
        @(negedge clk); bot_upd_i[1] = 0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        bus(0, 32'h028, 32'h0, 4'h0, ack, err, rd);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL race_ovr got %h want 3", rd); end
        bus(1, 32'h028, 32'h3, 4'h1, ack, err, rd);
        bus(0, 32'h100, 32'h0, 4'h0, ack, err, rd);
        checks++; if (rd !== 32'h0 || irq_o !== 1'b0) begin errors++; $display("FAIL irq_fall got %h irq %b want 0 0", rd, irq_o); end
        bus(0, 32'h000, 32'h0, 4'h0, ack, err, rd);
        checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL irq_indep got %h want 11223344", rd); end
    endtask

    task automatic test_err();
        bus(0, 32'h040, 32'h0, 4'h0, ack, err, rd);
        checks++; if ({ack, err} !== 2'b01 || rd !== 32'h0) begin errors++; $display("FAIL err_idx got %b %h want 01 0", {ack, err}, rd); end
        bus(0, 32'h010, 32'h0, 4'h0, ack, err, rd);
        checks++; if ({ack, err} !== 2'b01) begin errors++; $display("FAIL err_off got %b want 01", {ack, err}); end
        bus(1, 32'h000, 32'hFFFF_FFFF, 4'hF, ack, err, rd);
        checks++; if ({ack, err} !== 2'b01) begin errors++; $display("FAIL err_ro got %b want 01", {ack, err}); end
        @(posedge clk); #1;
        checks++; if (wb_err_o !== 1'b0) begin errors++; $display("FAIL err_width got %b want 0", wb_err_o); end
        bus(0, 32'h000, 32'h0, 4'h0, ack, err, rd);
        checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL err_nochg got %h want 11223344", rd); end
        bus(1, 32'h104, 32'h1, 4'h1, ack, err, rd);
        checks++; if ({ack, err} !== 2'b01) begin errors++; $display("FAIL err_id_wr got %b want 01", {ack, err}); end
        @(negedge clk);
        wb_adr_i = 32'h104; wb_we_i = 0; wb_cyc_i = 1; wb_stb_i = 1;
        @(posedge clk); #1;
        checks++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h0000_02B0) begin errors++; $display("FAIL id_rd got %b %h want 1 000002b0", wb_ack_o, wb_dat_o); end
        @(posedge clk); #1;
        checks++; if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin errors++; $display("FAIL ack_one_cycle got %b%b want 00", wb_ack_o, wb_err_o); end
        @(negedge clk); wb_cyc_i = 0; wb_stb_i = 0;
        @(posedge clk);
    endtask

    task automatic test_reset_mid();
        bus(1, 32'h02C, 32'h1, 4'h1, ack, err, rd);
        @(negedge clk);
        wb_we_i = 1; wb_adr_i = 32'h004; wb_dat_i = 32'h5A; wb_sel_i = 4'h1;
        wb_cyc_i = 1; wb_stb_i = 1; bot_upd_i[0] = 1;
        #2 rstn = 1'b0;
        @(posedge clk); #1;
        checks++; if (wb_ack_o !== 1'b0 || bot_ctrl_o !== 16'h0 || irq_o !== 1'b0) begin errors++; $display("FAIL rst_mid got ack %b ctrl %h irq %b want 0 0 0", wb_ack_o, bot_ctrl_o, irq_o); end
        @(negedge clk); wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        checks++; if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin errors++; $display("FAIL rst_noack got %b%b want 00", wb_ack_o, wb_err_o); end
        repeat (3) @(posedge clk);
        bus(0, 32'h008, 32'h0, 4'h0, ack, err, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL rst_edge got %h want 1", rd); end
        bus(0, 32'h004, 32'h0, 4'h0, ack, err, rd);
        checks++; if (rd !== 32'h0 || irq_o !== 1'b0) begin errors++; $display("FAIL rst_ctrl got %h irq %b want 0 0", rd, irq_o); end
        bot_upd_i[0] = 0;
    endtask

    initial begin
        test_reset();
        test_ctrl();
        test_update();
        test_irq();
        test_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
